// File: rtl/emac_rx_buf_pkg.sv
// emac_rx_buf_pkg: shared types and constants for the EMAC receive frame buffer.
// Holds the write/read FSM state encodings, the frame-length width and the
// length-FIFO entry type used by emac_rx_buf and emac_rx_len_fifo.
package emac_rx_buf_pkg;

    localparam int LEN_WIDTH = 16;

    typedef logic [LEN_WIDTH-1:0] len_entry_t;

    // Write-side FSM states
    typedef logic [1:0] wr_state_t;
    localparam logic [1:0] WR_SYNC = 2'd0;
    localparam logic [1:0] WR_IDLE = 2'd1;
    localparam logic [1:0] WR_RECV = 2'd2;
    localparam logic [1:0] WR_DROP = 2'd3;

    // Read-side FSM states
    typedef logic [1:0] rd_state_t;
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_LOAD = 2'd1;
    localparam logic [1:0] RD_SEND = 2'd2;

endpackage

// File: rtl/emac_rx_len_fifo.sv
// emac_rx_len_fifo: synchronous FIFO of committed frame lengths.
// First-word-fall-through: o_dout shows the head entry whenever o_empty is low.
// Pushes while full and pops while empty are ignored.
module emac_rx_len_fifo
    import emac_rx_buf_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  len_entry_t i_din,
    input  logic       i_pop,
    output len_entry_t o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    len_entry_t     r_mem [0:DEPTH-1];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Entry storage.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge i_clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/emac_rx_buf.sv
// emac_rx_buf: EMAC RX frame buffer. Bytes are stored speculatively in a
// circular buffer, committed on a good end-of-frame and rolled back on bad
// frames, drops and overflow. Committed frames are replayed on FrameLink.
// Optional statistics counters: define EMAC_RX_BUF_STATS_EN.
module emac_rx_buf
    import emac_rx_buf_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int LEN_FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_dvld,
    input  logic        i_rx_goodframe,
    input  logic        i_rx_badframe,
    input  logic        i_rx_framedrop,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_sof_n,
    output logic        o_tx_eof_n,
    output logic        o_tx_src_rdy_n,
    input  logic        i_tx_dst_rdy_n
`ifdef EMAC_RX_BUF_STATS_EN
    ,
    output logic [31:0] o_stat_good,
    output logic [31:0] o_stat_discard
`endif
);

    // ---------------- write side ----------------
    wr_state_t             r_wr_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_cm_ptr;
    len_entry_t            r_len;
    logic                  r_drop;

    // ---------------- read side -----------------
    rd_state_t             r_rd_state;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    len_entry_t            r_rem;
    logic                  r_first;
    logic [7:0]            r_ram_q;

    logic [7:0]            r_mem [0:(1 << ADDR_WIDTH) - 1];

    logic [ADDR_WIDTH-1:0] w_wr_next;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_eof;
    logic                  w_no_room;
    logic                  w_mem_we;
    logic                  w_commit;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_len_full;
    logic                  w_len_empty;
    len_entry_t            w_len_head;

    assign w_wr_next = r_wr_ptr + 1'b1;
    assign w_eof     = i_rx_goodframe || i_rx_badframe;
    // Full test uses the read pointer as registered at the start of the cycle.
    assign w_no_room = (w_wr_next == r_rd_ptr) || w_len_full;
    assign w_mem_we  = i_rx_dvld && !w_eof && !w_no_room &&
                       ((r_wr_state == WR_IDLE) || (r_wr_state == WR_RECV));
    // Simultaneous good and bad pulses count as bad.
    assign w_commit  = (r_wr_state == WR_RECV) && i_rx_goodframe && !i_rx_badframe &&
                       !(r_drop || i_rx_framedrop);

    emac_rx_len_fifo #(
        .DEPTH (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_commit),
        .i_din   (r_len),
        .i_pop   (w_pop),
        .o_dout  (w_len_head),
        .o_full  (w_len_full),
        .o_empty (w_len_empty)
    );

    // Write FSM: speculative store, commit or roll back at end of frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_state <= WR_SYNC;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_len      <= '0;
            r_drop     <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_SYNC: begin
                    // Wait for a gap so a frame cut by reset is never stored.
                    if (!i_rx_dvld) r_wr_state <= WR_IDLE;
                end
                WR_IDLE: begin
                    r_drop <= 1'b0;
                    if (!w_eof && i_rx_dvld) begin
                        // A first byte with no room cannot be stored either.
                        if (w_no_room) begin
                            r_wr_state <= WR_DROP;
                        end else begin
                            r_wr_ptr   <= w_wr_next;
                            r_len      <= len_entry_t'(1);
                            r_drop     <= i_rx_framedrop;
                            r_wr_state <= WR_RECV;
                        end
                    end
                end
                WR_RECV: begin
                    if (w_eof) begin
                        if (w_commit) r_cm_ptr <= r_wr_ptr;
                        else          r_wr_ptr <= r_cm_ptr;
                        r_wr_state <= WR_IDLE;
                    end else begin
                        if (i_rx_framedrop) r_drop <= 1'b1;
                        if (i_rx_dvld) begin
                            if (w_no_room) begin
                                r_wr_state <= WR_DROP;
                            end else begin
                                r_wr_ptr <= w_wr_next;
                                r_len    <= r_len + 1'b1;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (w_eof) begin
                        r_wr_ptr   <= r_cm_ptr;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_SYNC;
            endcase
        end
    end

    // Data buffer write port.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[r_wr_ptr] <= i_rx_data;
    end

    assign w_xfer = (r_rd_state == RD_SEND) && !i_tx_dst_rdy_n;
    assign w_last = (r_rem == len_entry_t'(1));
    assign w_pop  = ((r_rd_state == RD_IDLE) && !w_len_empty) ||
                    (w_xfer && w_last && !w_len_empty);

    // Read address: fetch the byte that will be on the output next cycle.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch
        // is inferred.
        w_rd_addr = r_rd_ptr;
        if (w_xfer) w_rd_addr = r_rd_ptr + 1'b1;
    end

    // Lookahead register: RAM read data driving the output byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_ram_q <= '0;
        else         r_ram_q <= r_mem[w_rd_addr];
    end

    // Read FSM: pop a length, prime the RAM, then stream the frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_ptr   <= '0;
            r_rem      <= '0;
            r_first    <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (!w_len_empty) begin
                        r_rem      <= w_len_head;
                        r_first    <= 1'b1;
                        r_rd_state <= RD_LOAD;
                    end
                end
                RD_LOAD: r_rd_state <= RD_SEND;
                RD_SEND: begin
                    if (w_xfer) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_rem    <= r_rem - 1'b1;
                        r_first  <= 1'b0;
                        if (w_last) begin
                            if (!w_len_empty) begin
                                r_rem      <= w_len_head;
                                r_first    <= 1'b1;
                                r_rd_state <= RD_LOAD;
                            end else begin
                                r_rd_state <= RD_IDLE;
                            end
                        end
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign o_tx_data      = r_ram_q;
    assign o_tx_src_rdy_n = !(r_rd_state == RD_SEND);
    assign o_tx_sof_n     = !((r_rd_state == RD_SEND) && r_first);
    assign o_tx_eof_n     = !((r_rd_state == RD_SEND) && w_last);

`ifdef EMAC_RX_BUF_STATS_EN
    logic [31:0] r_stat_good;
    logic [31:0] r_stat_discard;
    logic        w_discard;

    // Rolled-back frames, frames ended in DROP and zero-length frames.
    assign w_discard = ((r_wr_state == WR_RECV) && w_eof && !w_commit) ||
                       ((r_wr_state == WR_DROP) && w_eof) ||
                       ((r_wr_state == WR_IDLE) && w_eof);

    // Saturating frame counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_good    <= '0;
            r_stat_discard <= '0;
        end else begin
            if (w_commit && (r_stat_good != '1))     r_stat_good    <= r_stat_good + 32'd1;
            if (w_discard && (r_stat_discard != '1)) r_stat_discard <= r_stat_discard + 32'd1;
        end
    end

    assign o_stat_good    = r_stat_good;
    assign o_stat_discard = r_stat_discard;
`endif

endmodule

// File: tb/tb_emac_rx_buf.sv
// tb_emac_rx_buf: directed bench for emac_rx_buf. A large instance
// (ADDR_WIDTH=11) runs the frame table, the stalling sink and the reset
// sequence; a small instance (ADDR_WIDTH=6) runs the overflow case.
module tb_emac_rx_buf;

    localparam int E_GOOD = 0;
    localparam int E_BAD  = 1;
    localparam int E_BOTH = 2;

    typedef struct {
        string name;
        int    len;
        int    seed;
        int    endt;
        int    drop_at;
        int    exp_out;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] rx_data;
    logic       rx_dvld, rx_good, rx_bad, rx_fdrop;
    logic       sel;
    int         mode_b = 0;
    int         mode_s = 0;

    logic       b_dst_rdy_n, s_dst_rdy_n;
    logic [7:0] b_tx_data, s_tx_data;
    logic       b_sof_n, b_eof_n, b_src_rdy_n;
    logic       s_sof_n, s_eof_n, s_src_rdy_n;
`ifdef EMAC_RX_BUF_STATS_EN
    logic [31:0] b_stat_good, b_stat_disc, s_stat_good, s_stat_disc;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [9:0] cap_b[$];
    logic [9:0] cap_s[$];
    logic       held_b = 1'b0;
    logic [9:0] held_beat_b = '0;

    emac_rx_buf #(.ADDR_WIDTH(11), .LEN_FIFO_DEPTH(16)) dut_b (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rx_data),
        .i_rx_dvld      (rx_dvld & ~sel),
        .i_rx_goodframe (rx_good & ~sel),
        .i_rx_badframe  (rx_bad & ~sel),
        .i_rx_framedrop (rx_fdrop & ~sel),
        .o_tx_data      (b_tx_data),
        .o_tx_sof_n     (b_sof_n),
        .o_tx_eof_n     (b_eof_n),
        .o_tx_src_rdy_n (b_src_rdy_n),
        .i_tx_dst_rdy_n (b_dst_rdy_n)
`ifdef EMAC_RX_BUF_STATS_EN
        ,
        .o_stat_good    (b_stat_good),
        .o_stat_discard (b_stat_disc)
`endif
    );

    emac_rx_buf #(.ADDR_WIDTH(6), .LEN_FIFO_DEPTH(16)) dut_s (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rx_data),
        .i_rx_dvld      (rx_dvld & sel),
        .i_rx_goodframe (rx_good & sel),
        .i_rx_badframe  (rx_bad & sel),
        .i_rx_framedrop (rx_fdrop & sel),
        .o_tx_data      (s_tx_data),
        .o_tx_sof_n     (s_sof_n),
        .o_tx_eof_n     (s_eof_n),
        .o_tx_src_rdy_n (s_src_rdy_n),
        .i_tx_dst_rdy_n (s_dst_rdy_n)
`ifdef EMAC_RX_BUF_STATS_EN
        ,
        .o_stat_good    (s_stat_good),
        .o_stat_discard (s_stat_disc)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sink ready: 0 = always ready, 1 = stalled, 2 = toggle every cycle.
    initial begin
        b_dst_rdy_n = 1'b0;
        s_dst_rdy_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode_b == 0)      b_dst_rdy_n = 1'b0;
            else if (mode_b == 1) b_dst_rdy_n = 1'b1;
            else                  b_dst_rdy_n = ~b_dst_rdy_n;
            if (mode_s == 0)      s_dst_rdy_n = 1'b0;
            else if (mode_s == 1) s_dst_rdy_n = 1'b1;
            else                  s_dst_rdy_n = ~s_dst_rdy_n;
        end
    end

    // Capture every transfer as {data, sof_n, eof_n}.
    always @(negedge clk) begin
        if (!reset) begin
            if (!b_src_rdy_n && !b_dst_rdy_n) cap_b.push_back({b_tx_data, b_sof_n, b_eof_n});
            if (!s_src_rdy_n && !s_dst_rdy_n) cap_s.push_back({s_tx_data, s_sof_n, s_eof_n});
        end
    end

    // Output must hold still across a stalled cycle.
    always @(negedge clk) begin
        if (!reset && held_b)
            check("stall_hold", 32'({b_src_rdy_n, b_tx_data, b_sof_n, b_eof_n}),
                  32'({1'b0, held_beat_b}));
        held_b      <= !reset && !b_src_rdy_n && b_dst_rdy_n;
        held_beat_b <= {b_tx_data, b_sof_n, b_eof_n};
    end

    function automatic int qsize(input int which);
        return (which == 0) ? cap_b.size() : cap_s.size();
    endfunction

    function automatic logic [10:0] pop_beat(input int which);
        if (which == 0) begin
            if (cap_b.size() > 0) return {1'b0, cap_b.pop_front()};
        end else begin
            if (cap_s.size() > 0) return {1'b0, cap_s.pop_front()};
        end
        return 11'h7ff;
    endfunction

    task automatic wait_beats(input int which, input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (qsize(which) >= n) break;
            @(posedge clk);
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic expect_frame(input int which, input string name, input int len, input int seed);
        logic [10:0] got;
        logic [10:0] want;
        for (int i = 0; i < len; i++) begin
            got  = pop_beat(which);
            want = {1'b0, 8'(seed + i), (i == 0) ? 1'b0 : 1'b1, (i == len - 1) ? 1'b0 : 1'b1};
            check($sformatf("%s_byte%0d", name, i), 32'(got), 32'(want));
        end
    endtask

    task automatic send_frame(input int len, input int seed, input int endt, input int drop_at);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            rx_dvld  = 1'b1;
            rx_data  = 8'(seed + i);
            rx_fdrop = (i == drop_at);
        end
        @(posedge clk);
        #1;
        rx_dvld  = 1'b0;
        rx_fdrop = 1'b0;
        rx_good  = (endt == E_GOOD) || (endt == E_BOTH);
        rx_bad   = (endt == E_BAD) || (endt == E_BOTH);
        @(posedge clk);
        #1;
        rx_good = 1'b0;
        rx_bad  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        vec_t        vecs[7];
        logic [10:0] exp_cm_b;
        logic [5:0]  exp_cm_s;
        int          exp_good;
        int          exp_disc;

        vecs[0] = '{"good64",     64, 'h00, E_GOOD, -1, 64};
        vecs[1] = '{"bad100",    100, 'h40, E_BAD,  -1,  0};
        vecs[2] = '{"good60",     60, 'h80, E_GOOD, -1, 60};
        vecs[3] = '{"fdrop30",    30, 'h11, E_GOOD, 10,  0};
        vecs[4] = '{"zero_len",    0, 'h00, E_GOOD, -1,  0};
        vecs[5] = '{"good_bad5",   5, 'h22, E_BOTH, -1,  0};
        vecs[6] = '{"good1",       1, 'h33, E_GOOD, -1,  1};

        exp_cm_b = '0;
        exp_cm_s = '0;
        exp_good = 0;
        exp_disc = 0;

        reset    = 1'b1;
        rx_data  = '0;
        rx_dvld  = 1'b0;
        rx_good  = 1'b0;
        rx_bad   = 1'b0;
        rx_fdrop = 1'b0;
        sel      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_src_rdy_n", 32'(b_src_rdy_n), 32'd1);
        check("rst_sof_n",     32'(b_sof_n),     32'd1);
        check("rst_eof_n",     32'(b_eof_n),     32'd1);
        check("rst_data",      32'(b_tx_data),   32'd0);
        check("rst_cm_ptr",    32'(dut_b.r_cm_ptr), 32'd0);
`ifdef EMAC_RX_BUF_STATS_EN
        check("rst_stat_good", b_stat_good, 32'd0);
        check("rst_stat_disc", b_stat_disc, 32'd0);
`endif

        // Frame table, sink always ready.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].len, vecs[v].seed, vecs[v].endt, vecs[v].drop_at);
            wait_beats(0, vecs[v].exp_out, vecs[v].len + 50);
            check({vecs[v].name, "_count"}, 32'(cap_b.size()), 32'(vecs[v].exp_out));
            expect_frame(0, vecs[v].name, vecs[v].exp_out, vecs[v].seed);
            cap_b.delete();
            exp_cm_b = exp_cm_b + 11'(vecs[v].exp_out);
            if (vecs[v].exp_out > 0) exp_good++;
            else                     exp_disc++;
            check({vecs[v].name, "_cm_ptr"}, 32'(dut_b.r_cm_ptr), 32'(exp_cm_b));
            check({vecs[v].name, "_wr_ptr"}, 32'(dut_b.r_wr_ptr), 32'(exp_cm_b));
`ifdef EMAC_RX_BUF_STATS_EN
            check({vecs[v].name, "_stat_good"}, b_stat_good, 32'(exp_good));
            check({vecs[v].name, "_stat_disc"}, b_stat_disc, 32'(exp_disc));
`endif
        end

        // Toggling sink over back-to-back 1, 2 and 1500 byte frames.
        mode_b = 2;
        send_frame(1,    'hA0, E_GOOD, -1);
        send_frame(2,    'hB0, E_GOOD, -1);
        send_frame(1500, 'h05, E_GOOD, -1);
        wait_beats(0, 1503, 5000);
        check("toggle_count", 32'(cap_b.size()), 32'd1503);
        expect_frame(0, "toggle_f1", 1,    'hA0);
        expect_frame(0, "toggle_f2", 2,    'hB0);
        expect_frame(0, "toggle_f3", 1500, 'h05);
        cap_b.delete();
        exp_cm_b = exp_cm_b + 11'd1503;
        check("toggle_cm_ptr", 32'(dut_b.r_cm_ptr), 32'(exp_cm_b));
        mode_b = 0;

        // Small buffer: second frame overflows while the sink is stalled.
        sel    = 1'b1;
        mode_s = 1;
        repeat (3) @(posedge clk);
        send_frame(40, 'h10, E_GOOD, -1);
        send_frame(40, 'h60, E_GOOD, -1);
        repeat (10) @(posedge clk);
        check("ovf_stalled_count", 32'(cap_s.size()), 32'd0);
        exp_cm_s = 6'd40;
        check("ovf_cm_ptr", 32'(dut_s.r_cm_ptr), 32'(exp_cm_s));
        check("ovf_wr_ptr", 32'(dut_s.r_wr_ptr), 32'(exp_cm_s));
`ifdef EMAC_RX_BUF_STATS_EN
        check("ovf_stat_good", s_stat_good, 32'd1);
        check("ovf_stat_disc", s_stat_disc, 32'd1);
`endif
        mode_s = 0;
        wait_beats(1, 40, 200);
        check("ovf_count", 32'(cap_s.size()), 32'd40);
        expect_frame(1, "ovf_first", 40, 'h10);
        cap_s.delete();
        send_frame(40, 'h70, E_GOOD, -1);
        wait_beats(1, 40, 200);
        check("wrap_count", 32'(cap_s.size()), 32'd40);
        expect_frame(1, "wrap", 40, 'h70);
        cap_s.delete();
        exp_cm_s = exp_cm_s + 6'd40;
        check("wrap_cm_ptr", 32'(dut_s.r_cm_ptr), 32'(exp_cm_s));
        sel = 1'b0;

        // Reset mid-frame with a committed frame waiting at a stalled sink.
        mode_b = 1;
        repeat (2) @(posedge clk);
        send_frame(10, 'hC0, E_GOOD, -1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre_rst_src_rdy_n", 32'(b_src_rdy_n), 32'd0);
        check("pre_rst_sof_n",     32'(b_sof_n),     32'd0);
        check("pre_rst_data",      32'(b_tx_data),   32'hC0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            reset   = (i == 20);
            rx_dvld = 1'b1;
            rx_data = 8'(8'hD0 + i);
            if (i == 21) begin
                @(negedge clk);
                check("midrst_src_rdy_n", 32'(b_src_rdy_n), 32'd1);
                check("midrst_sof_n",     32'(b_sof_n),     32'd1);
                check("midrst_eof_n",     32'(b_eof_n),     32'd1);
                check("midrst_data",      32'(b_tx_data),   32'd0);
            end
        end
        @(posedge clk);
        #1;
        rx_dvld = 1'b0;
        rx_good = 1'b1;
        @(posedge clk);
        #1;
        rx_good = 1'b0;
        mode_b  = 0;
        repeat (40) @(posedge clk);
        check("midrst_no_output", 32'(cap_b.size()), 32'd0);
        check("midrst_cm_ptr", 32'(dut_b.r_cm_ptr), 32'd0);
`ifdef EMAC_RX_BUF_STATS_EN
        check("midrst_stat_good", b_stat_good, 32'd0);
        check("midrst_stat_disc", b_stat_disc, 32'd0);
`endif
        send_frame(25, 'hE0, E_GOOD, -1);
        wait_beats(0, 25, 100);
        check("post_rst_count", 32'(cap_b.size()), 32'd25);
        expect_frame(0, "post_rst", 25, 'hE0);
        check("post_rst_cm_ptr", 32'(dut_b.r_cm_ptr), 32'd25);
`ifdef EMAC_RX_BUF_STATS_EN
        check("post_rst_stat_good", b_stat_good, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
